iob_vexriscv_axi_rd_arb: RTL

Two-master AXI4 read-channel arbiter. It shares one memory-side AXI4 read port between the VexRiscv instruction bus (m0) and data bus (m1), which sit downstream of the CPU wrapper's address remapping. It grants one burst at a time using round-robin priority and routes the R channel back to the granted master until the final beat. It also flags R bursts whose length does not match the requested arlen.

---
 rtl/iob_vexriscv_axi_rd_arb_if.sv | 43 ++++
 rtl/iob_vexriscv_axi_rd_arb.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/iob_vexriscv_axi_rd_arb_if.sv
// AXI4 read-only channel bundle (AR + R) shared by the two CPU-side masters
// and the memory-side port of iob_vexriscv_axi_rd_arb.
interface iob_vexriscv_axi_rd_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 1,
  parameter int LEN_W  = 8
);
  // Handshake rule for both channels: a transfer happens on the rising clock
  // edge where valid and ready are both high; once valid is raised the source
  // holds valid and its payload stable until that edge, and valid never waits
  // on ready.
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [LEN_W-1:0]  arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [1:0]        arlock;
  logic [3:0]        arcache;
  logic [3:0]        arqos;
  logic [2:0]        arprot;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [ID_W-1:0]   rid;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, arlock, arcache,
           arqos, arprot, rready,
    input  arready, rvalid, rdata, rid, rresp, rlast
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, arlock, arcache,
           arqos, arprot, rready,
    output arready, rvalid, rdata, rid, rresp, rlast
  );
endinterface

// File: rtl/iob_vexriscv_axi_rd_arb.sv
// Round-robin arbiter sharing one AXI4 read port between the VexRiscv iBus
// (m0) and dBus (m1); one burst in flight, R routed by grant, length checked.
module iob_vexriscv_axi_rd_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 1,
  parameter int LEN_W  = 8
) (
  input  logic                  clk_i,
  input  logic                  cke_i,
  input  logic                  arst_n_i,
  iob_vexriscv_axi_rd_arb_if.slave  m0,
  iob_vexriscv_axi_rd_arb_if.slave  m1,
  iob_vexriscv_axi_rd_arb_if.master s,
  output logic                  err_o,
  input  logic                  err_clr_i,
  output logic [1:0]            dbg_state_o,
  output logic [LEN_W:0]        dbg_beat_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [LEN_W:0] CNT_ONE = {{LEN_W{1'b0}}, 1'b1};

  state_t           r_state;
  logic             r_gnt;
  logic             r_last_gnt;
  logic [LEN_W:0]   r_beat_cnt;
  logic [LEN_W-1:0] r_arlen;
  logic             r_err;

  logic             w_in_addr;
  logic             w_in_data;
  logic             w_any_req;
  logic             w_pick;
  logic             w_ar_hs;
  logic             w_r_hs;
  logic [LEN_W-1:0] w_gnt_arlen;
  logic [LEN_W:0]   w_beat_num;
  logic [LEN_W:0]   w_exp_beats;
  logic             w_err_set;

  assign w_in_addr = (r_state == ST_ADDR);
  assign w_in_data = (r_state == ST_DATA);
  assign w_any_req = m0.arvalid | m1.arvalid;

  // m1 wins when alone, or on a tie when m0 was the one served last.
  assign w_pick = m1.arvalid & (~m0.arvalid | ~r_last_gnt);

  assign w_ar_hs     = s.arvalid & s.arready;
  assign w_r_hs      = s.rvalid & s.rready;
  assign w_gnt_arlen = r_gnt ? m1.arlen : m0.arlen;
  assign w_beat_num  = r_beat_cnt + CNT_ONE;
  assign w_exp_beats = {1'b0, r_arlen} + CNT_ONE;

  // rlast on the wrong beat, or the expected final beat arriving without it.
  assign w_err_set = w_in_data & w_r_hs &
                     ((s.rlast & (w_beat_num != w_exp_beats)) |
                      (~s.rlast & (w_beat_num == w_exp_beats)));

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state    <= ST_IDLE;
      r_gnt      <= 1'b0;
      r_last_gnt <= 1'b1;
      r_beat_cnt <= '0;
      r_arlen    <= '0;
      r_err      <= 1'b0;
    end else if (cke_i) begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_gnt      <= w_pick;
            r_last_gnt <= w_pick;
            r_state    <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (w_ar_hs) begin
            r_beat_cnt <= '0;
            r_arlen    <= w_gnt_arlen;
            r_state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_r_hs) begin
            r_beat_cnt <= w_beat_num;
            if (s.rlast) begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (err_clr_i) begin
        r_err <= 1'b0;
      end
    end
  end

  assign err_o          = r_err;
  assign dbg_state_o    = r_state;
  assign dbg_beat_cnt_o = r_beat_cnt;

  // Memory-side AR: granted master's request, forced to zero outside ADDR.
  always_comb begin
    s.arvalid = 1'b0;
    s.araddr  = '0;
    s.arid    = '0;
    s.arlen   = '0;
    s.arsize  = '0;
    s.arburst = '0;
    s.arlock  = '0;
    s.arcache = '0;
    s.arqos   = '0;
    s.arprot  = '0;
    if (w_in_addr) begin
      if (r_gnt) begin
        s.arvalid = m1.arvalid;
        s.araddr  = m1.araddr;
        s.arid    = m1.arid;
        s.arlen   = m1.arlen;
        s.arsize  = m1.arsize;
        s.arburst = m1.arburst;
        s.arlock  = m1.arlock;
        s.arcache = m1.arcache;
        s.arqos   = m1.arqos;
        s.arprot  = m1.arprot;
      end else begin
        s.arvalid = m0.arvalid;
        s.araddr  = m0.araddr;
        s.arid    = m0.arid;
        s.arlen   = m0.arlen;
        s.arsize  = m0.arsize;
        s.arburst = m0.arburst;
        s.arlock  = m0.arlock;
        s.arcache = m0.arcache;
        s.arqos   = m0.arqos;
        s.arprot  = m0.arprot;
      end
    end
  end

  assign m0.arready = w_in_addr & ~r_gnt & s.arready;
  assign m1.arready = w_in_addr &  r_gnt & s.arready;

  assign s.rready = w_in_data & (r_gnt ? m1.rready : m0.rready);

  // R channel is a pure pass-through to whichever master holds the grant.
  always_comb begin
    m0.rvalid = 1'b0;
    m0.rdata  = '0;
    m0.rid    = '0;
    m0.rresp  = '0;
    m0.rlast  = 1'b0;
    if (w_in_data && !r_gnt) begin
      m0.rvalid = s.rvalid;
      m0.rdata  = s.rdata;
      m0.rid    = s.rid;
      m0.rresp  = s.rresp;
      m0.rlast  = s.rlast;
    end
  end

  always_comb begin
    m1.rvalid = 1'b0;
    m1.rdata  = '0;
    m1.rid    = '0;
    m1.rresp  = '0;
    m1.rlast  = 1'b0;
    if (w_in_data && r_gnt) begin
      m1.rvalid = s.rvalid;
      m1.rdata  = s.rdata;
      m1.rid    = s.rid;
      m1.rresp  = s.rresp;
      m1.rlast  = s.rlast;
    end
  end

endmodule
